// File: rtl/proc_trace_capture_if.sv
// Read side of the trace FIFO: head entry presented with a valid/ready handshake.
interface proc_trace_capture_if #(
    parameter int DATA_W = 32,
    parameter int TS_W   = 16
);
    logic              Rd_Valid;
    logic              Rd_Ready;
    logic [DATA_W-1:0] Rd_ALU;
    logic [DATA_W-1:0] Rd_MEM;
    logic [TS_W-1:0]   Rd_Ts;

    modport master (output Rd_Valid, Rd_ALU, Rd_MEM, Rd_Ts, input Rd_Ready);
    modport slave  (input Rd_Valid, Rd_ALU, Rd_MEM, Rd_Ts, output Rd_Ready);
endinterface

// File: rtl/proc_trace_capture.sv
// Samples the processor ALU/MEM result buses, keeps changed samples with a cycle
// timestamp, and queues them in a first-word-fall-through FIFO for a consumer.
module proc_trace_capture #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int CHANGE_ONLY = 1,
    parameter int TS_W        = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Cap_En,
    input  logic                   Clear,
    input  logic [DATA_W-1:0]      ALU_In,
    input  logic [DATA_W-1:0]      MEM_In,
    proc_trace_capture_if.master   rd,
    output logic [$clog2(DEPTH):0] Count,
    output logic                   Full,
    output logic                   Empty,
    output logic                   Overflow,
    output logic [7:0]             Drop_Cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARM  = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [DATA_W-1:0] last_alu_q, last_alu_d;
    logic [DATA_W-1:0] last_mem_q, last_mem_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        drop_q, drop_d;

    logic [DATA_W-1:0] alu_mem [DEPTH];
    logic [DATA_W-1:0] mem_mem [DEPTH];
    logic [TS_W-1:0]   ts_mem  [DEPTH];

    logic              sample_diff;
    logic              push_req;
    logic              pop;
    logic              wr_en;
    logic              drop;
    logic [TS_W-1:0]   sample_ts;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign Count    = count_q;
    assign Empty    = (count_q == '0);
    assign Full     = (count_q == DEPTH_C);
    assign Overflow = ovf_q;
    assign Drop_Cnt = drop_q;

    // Head entry falls through from storage; forced to zero while empty.
    assign rd.Rd_Valid = !Empty;
    assign rd.Rd_ALU   = Empty ? '0 : alu_mem[rd_ptr_q];
    assign rd.Rd_MEM   = Empty ? '0 : mem_mem[rd_ptr_q];
    assign rd.Rd_Ts    = Empty ? '0 : ts_mem[rd_ptr_q];

    assign sample_diff = (ALU_In != last_alu_q) || (MEM_In != last_mem_q);
    assign sample_ts   = (state_q == ARM) ? '0 : ts_q;
    assign pop         = rd.Rd_Valid && rd.Rd_Ready && !Clear;
    assign push_req    = !Clear && ((state_q == ARM) ||
                         ((state_q == RUN) && ((CHANGE_ONLY == 0) || sample_diff)));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign wr_en       = push_req && (!Full || pop);
    assign drop        = push_req && Full && !pop;

    always_comb begin
        state_d    = state_q;
        ts_d       = ts_q;
        last_alu_d = last_alu_q;
        last_mem_d = last_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        drop_d     = drop_q;
        if (Clear) begin
            state_d  = IDLE;
            ts_d     = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            drop_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ts_d = '0;
                    if (Cap_En) state_d = ARM;
                end
                ARM, RUN: begin
                    ts_d    = ts_q + 1'b1;
                    state_d = Cap_En ? RUN : IDLE;
                end
                default: begin
                    ts_d    = '0;
                    state_d = IDLE;
                end
            endcase
            // Dropped samples still become the change-detection reference.
            if (push_req) begin
                last_alu_d = ALU_In;
                last_mem_d = MEM_In;
            end
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(wr_en) - CW'(pop);
            if (drop) begin
                ovf_d  = 1'b1;
                drop_d = sat_inc8(drop_q);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            ts_q       <= '0;
            last_alu_q <= '0;
            last_mem_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_d;
            last_alu_q <= last_alu_d;
            last_mem_q <= last_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            alu_mem[wr_ptr_q] <= ALU_In;
            mem_mem[wr_ptr_q] <= MEM_In;
            ts_mem[wr_ptr_q]  <= sample_ts;
        end
    end
endmodule

// File: tb/tb_proc_trace_capture.sv
// Bench for proc_trace_capture: a change-only and an every-cycle instance share
// stimulus; a reference model fills per-instance scoreboards checked each cycle.
module tb_proc_trace_capture;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int TS_W   = 16;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int S_IDLE = 0;
    localparam int S_ARM  = 1;
    localparam int S_RUN  = 2;

    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] mem;
        logic [TS_W-1:0]   ts;
    } ent_t;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              Cap_En = 1'b0;
    logic              Clear = 1'b0;
    logic [DATA_W-1:0] ALU_In = '0;
    logic [DATA_W-1:0] MEM_In = '0;
    logic              rdy0 = 1'b0;
    logic              rdy1 = 1'b0;
    logic [CW-1:0]     count0, count1;
    logic              full0, full1, empty0, empty1, ovf0, ovf1;
    logic [7:0]        drop0, drop1;

    int checks = 0;
    int errors = 0;

    int                m_st   [2];
    logic [TS_W-1:0]   m_ts   [2];
    logic [DATA_W-1:0] m_la   [2];
    logic [DATA_W-1:0] m_lm   [2];
    logic              m_ovf  [2];
    int                m_drop [2];
    ent_t              q0[$];
    ent_t              q1[$];

    proc_trace_capture_if #(.DATA_W(DATA_W), .TS_W(TS_W)) if0 ();
    proc_trace_capture_if #(.DATA_W(DATA_W), .TS_W(TS_W)) if1 ();
    assign if0.Rd_Ready = rdy0;
    assign if1.Rd_Ready = rdy1;

    proc_trace_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CHANGE_ONLY(1), .TS_W(TS_W)) dut0 (
        .Clk(Clk), .Reset(Reset), .Cap_En(Cap_En), .Clear(Clear),
        .ALU_In(ALU_In), .MEM_In(MEM_In), .rd(if0),
        .Count(count0), .Full(full0), .Empty(empty0), .Overflow(ovf0), .Drop_Cnt(drop0));

    proc_trace_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CHANGE_ONLY(0), .TS_W(TS_W)) dut1 (
        .Clk(Clk), .Reset(Reset), .Cap_En(Cap_En), .Clear(Clear),
        .ALU_In(ALU_In), .MEM_In(MEM_In), .rd(if1),
        .Count(count1), .Full(full1), .Empty(empty1), .Overflow(ovf1), .Drop_Cnt(drop1));

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int q_size(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic ent_t q_head(input int k);
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    task automatic q_pop(input int k);
        if (k == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic q_push(input int k, input ent_t e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic q_clear(input int k);
        if (k == 0) q0.delete();
        else        q1.delete();
    endtask

    task automatic model_reset(input int k);
        q_clear(k);
        m_st[k]   = S_IDLE;
        m_ts[k]   = '0;
        m_la[k]   = '0;
        m_lm[k]   = '0;
        m_ovf[k]  = 1'b0;
        m_drop[k] = 0;
    endtask

    // Advance the reference by one clock using the inputs currently applied.
    task automatic model_step(input int k, input logic rdy, input bit change_only);
        bit   was_full, pop, push;
        ent_t e;
        was_full = (q_size(k) == DEPTH);
        pop      = (q_size(k) != 0) && rdy;
        if (Clear) begin
            q_clear(k);
            m_st[k]   = S_IDLE;
            m_ts[k]   = '0;
            m_ovf[k]  = 1'b0;
            m_drop[k] = 0;
            return;
        end
        push = (m_st[k] == S_ARM) ||
               ((m_st[k] == S_RUN) && (!change_only || ALU_In != m_la[k] || MEM_In != m_lm[k]));
        if (pop) q_pop(k);
        if (push) begin
            e.alu = ALU_In;
            e.mem = MEM_In;
            e.ts  = (m_st[k] == S_ARM) ? '0 : m_ts[k];
            if (!was_full || pop) q_push(k, e);
            else begin
                m_ovf[k] = 1'b1;
                if (m_drop[k] < 255) m_drop[k]++;
            end
            m_la[k] = ALU_In;
            m_lm[k] = MEM_In;
        end
        if (m_st[k] == S_IDLE) begin
            m_ts[k] = '0;
            if (Cap_En) m_st[k] = S_ARM;
        end else begin
            m_ts[k] = m_ts[k] + 1'b1;
            m_st[k] = Cap_En ? S_RUN : S_IDLE;
        end
    endtask

    task automatic check_dut(input int k);
        logic              v, f, em, o;
        logic [DATA_W-1:0] a, m;
        logic [TS_W-1:0]   t;
        logic [CW-1:0]     c;
        logic [7:0]        d;
        ent_t              h;
        if (k == 0) begin
            v = if0.Rd_Valid; a = if0.Rd_ALU; m = if0.Rd_MEM; t = if0.Rd_Ts;
            c = count0; f = full0; em = empty0; o = ovf0; d = drop0;
        end else begin
            v = if1.Rd_Valid; a = if1.Rd_ALU; m = if1.Rd_MEM; t = if1.Rd_Ts;
            c = count1; f = full1; em = empty1; o = ovf1; d = drop1;
        end
        h = '0;
        if (q_size(k) != 0) h = q_head(k);
        chk($sformatf("d%0d.valid", k), v, q_size(k) != 0);
        chk($sformatf("d%0d.alu", k), a, h.alu);
        chk($sformatf("d%0d.mem", k), m, h.mem);
        chk($sformatf("d%0d.ts", k), t, h.ts);
        chk($sformatf("d%0d.count", k), c, q_size(k));
        chk($sformatf("d%0d.full", k), f, q_size(k) == DEPTH);
        chk($sformatf("d%0d.empty", k), em, q_size(k) == 0);
        chk($sformatf("d%0d.overflow", k), o, m_ovf[k]);
        chk($sformatf("d%0d.drop", k), d, m_drop[k]);
    endtask

    task automatic cyc();
        model_step(0, rdy0, 1'b1);
        model_step(1, rdy1, 1'b0);
        @(posedge Clk);
        #1;
        check_dut(0);
        check_dut(1);
    endtask

    task automatic apply_reset();
        Reset = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        check_dut(0);
        check_dut(1);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
    endtask

    initial begin
        #2;
        Cap_En = 1'b1; ALU_In = 32'h5; MEM_In = 32'h0;
        apply_reset();
        chk("reset.rd_ts0", if0.Rd_Ts, 16'h0);

        // Constant inputs: only the ARM sample is kept.
        repeat (10) cyc();
        chk("const.count0", count0, 5'd1);
        chk("const.alu0", if0.Rd_ALU, 32'h5);
        chk("const.ts0", if0.Rd_Ts, 16'h0);

        // Stepping ALU with the consumer always ready.
        Clear = 1'b1; cyc(); Clear = 1'b0;
        ALU_In = 32'h0; rdy0 = 1'b1; rdy1 = 1'b1;
        cyc();
        cyc();
        for (int i = 1; i <= 3; i++) begin
            ALU_In = i;
            cyc();
            chk($sformatf("step%0d.ts0", i), if0.Rd_Ts, i);
            chk($sformatf("step%0d.alu0", i), if0.Rd_ALU, i);
        end
        Cap_En = 1'b0;
        cyc();
        chk("step.empty0", empty0, 1'b1);

        // Every-cycle capture overruns the FIFO.
        Cap_En = 1'b1; ALU_In = 32'h77; MEM_In = 32'h88; rdy0 = 1'b0; rdy1 = 1'b0;
        apply_reset();
        repeat (21) cyc();
        chk("fill.count1", count1, 5'd16);
        chk("fill.full1", full1, 1'b1);
        chk("fill.ovf1", ovf1, 1'b1);
        chk("fill.drop1", drop1, 8'd4);
        chk("fill.head_ts1", if1.Rd_Ts, 16'h0);

        // Full FIFO with simultaneous push and pop.
        rdy1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ALU_In = 32'h100 + i;
            cyc();
        end
        chk("pp.count1", count1, 5'd16);
        chk("pp.drop1", drop1, 8'd4);
        chk("pp.head_ts1", if1.Rd_Ts, 16'd5);

        // Asynchronous reset with seven entries held.
        rdy1 = 1'b0;
        Clear = 1'b1; cyc(); Clear = 1'b0;
        cyc();
        for (int i = 0; i < 7; i++) begin
            ALU_In = 32'h200 + i;
            cyc();
        end
        chk("mid.count0", count0, 5'd7);
        apply_reset();
        chk("rst.count0", count0, 5'd0);
        chk("rst.valid0", if0.Rd_Valid, 1'b0);
        chk("rst.ovf0", ovf0, 1'b0);
        cyc();
        cyc();
        chk("rearm.count0", count0, 5'd1);
        chk("rearm.ts0", if0.Rd_Ts, 16'h0);

        // Clear wins over Cap_En on a full FIFO.
        repeat (17) cyc();
        chk("pre_clr.full1", full1, 1'b1);
        Clear = 1'b1;
        cyc();
        Clear = 1'b0;
        chk("clr.count1", count1, 5'd0);
        chk("clr.ovf1", ovf1, 1'b0);
        chk("clr.drop1", drop1, 8'd0);
        cyc();
        chk("clr_idle.count1", count1, 5'd0);
        cyc();
        chk("clr_arm.count1", count1, 5'd1);
        chk("clr_arm.ts1", if1.Rd_Ts, 16'h0);

        // Drop counter saturation.
        repeat (280) cyc();
        chk("sat.drop1", drop1, 8'd255);

        // Drain, including pops requested while empty.
        Cap_En = 1'b0; rdy0 = 1'b1; rdy1 = 1'b1;
        repeat (20) cyc();
        chk("drain.empty0", empty0, 1'b1);
        chk("drain.empty1", empty1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/proc_trace_capture.md
Name: proc_trace_capture

Overview:
- Observer-side counterpart to the processor's result outputs. It samples the processor's ALU_Out and MEM_Out buses every clock, filters out unchanged samples, and timestamps each kept sample with a cycle counter.
- Kept samples go into a FIFO that a consumer (bench, UART dumper, debug port) drains over a valid/ready read interface.
- Sits beside the processor top level, in the same clock domain.

Parameters:
- DATA_W, 32, width of each sampled bus.
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- CHANGE_ONLY, 1, 1 = store a sample only when it differs from the last stored sample; 0 = store every cycle while running.
- TS_W, 16, timestamp counter width.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Cap_En  in  1  capture enable (level).
- Clear  in  1  synchronous clear: empties FIFO, clears Overflow and Drop_Cnt, returns to IDLE.
- ALU_In  in  DATA_W  processor ALU_Out.
- MEM_In  in  DATA_W  processor MEM_Out.
- Rd_Ready  in  1  consumer accepts head entry.
- Rd_Valid  out  1  head entry is valid.
- Rd_ALU  out  DATA_W  head ALU sample.
- Rd_MEM  out  DATA_W  head MEM sample.
- Rd_Ts  out  TS_W  head timestamp.
- Count  out  clog2(DEPTH)+1  current occupancy.
- Full  out  1  Count == DEPTH.
- Empty  out  1  Count == 0.
- Overflow  out  1  sticky; a sample was dropped.
- Drop_Cnt  out  8  number of dropped samples, saturating.

Behaviour:
- Reset (Reset=0, asynchronous): state IDLE, FIFO pointers 0, Count=0, Empty=1, Full=0, Rd_Valid=0, Overflow=0, Drop_Cnt=0, timestamp 0, last-stored registers 0. Rd_ALU, Rd_MEM and Rd_Ts read 0. Reset mid-capture discards all contents.
- FSM:
  - IDLE: timestamp held at 0, no pushes. Cap_En=1 -> ARM.
  - ARM (one cycle): push {ALU_In, MEM_In, ts=0} unconditionally and load the last-stored registers. Next state RUN, or IDLE if Cap_En=0.
  - RUN: timestamp increments by 1 per cycle, wrapping 2^TS_W-1 -> 0. Push when CHANGE_ONLY=0, or when either input bus differs from the last-stored value. Each push updates the last-stored registers. Cap_En=0 -> IDLE at the next edge; the current cycle's sample is still evaluated.
  - Clear=1 in any state -> IDLE with FIFO emptied. Clear has priority over Cap_En, push and pop in the same cycle.
- Timestamp stored with an entry = counter value in the sampling cycle. ARM uses 0, the first RUN cycle uses 1.
- Read side is first-word fall-through:
  - Rd_Valid = !Empty, and the head entry is on Rd_* combinationally from FIFO storage.
  - Pop occurs when Rd_Valid && Rd_Ready. The next entry appears in the following cycle.
  - Rd_* are stable while Rd_Valid=1 and Rd_Ready=0.
- Push latency: a sample taken at edge N is visible on Rd_* (if the FIFO was empty) with Rd_Valid=1 after edge N.
- Simultaneous push and pop: Count unchanged. This is allowed when Full=1, so no drop occurs.
- Push when Full=1 without a pop:
  - The sample is dropped; Overflow is set (sticky until Reset or Clear); Drop_Cnt increments and saturates at 255.
  - The last-stored registers are still updated, so change detection compares against the dropped sample.
- Pop when Empty: ignored.
- Pointers wrap modulo DEPTH. Count is tracked separately so Full and Empty are unambiguous.

Test Plan:
- Reset then Cap_En=1, ALU_In=0x5, MEM_In=0x0 constant for 10 cycles, Rd_Ready=0, CHANGE_ONLY=1 -> exactly one entry {0x5, 0x0, ts=0}; Count=1.
- RUN with ALU_In stepping 1,2,3 on consecutive cycles, Rd_Ready=1 -> entries read back in order with timestamps 1,2,3; Empty=1 afterwards.
- CHANGE_ONLY=0, Rd_Ready=0, 20 capture cycles, DEPTH=16 -> Full=1, Count=16, Overflow=1, Drop_Cnt=4; the first 16 samples read back intact.
- FIFO full with Rd_Ready=1 and a changing input -> push and pop together, Count stays 16, Drop_Cnt unchanged.
- Assert Reset low mid-RUN with Count=7 -> immediately Count=0, Rd_Valid=0, Overflow=0. After release with Cap_En=1 -> ARM entry ts=0.
- Clear=1 with Cap_En=1 and Full=1 -> next cycle Count=0, Overflow=0, state IDLE; the following cycle ARM pushes ts=0.
